// File: rtl/inst_fetch_pf_if.sv
// Fetch-stage bus bundle: redirect input, instruction memory port and decode handshake.
interface inst_fetch_pf_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 32
);
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_npc;

  // Environment side: drives redirect, memory data and decode ready.
  modport master (
    output redirect_valid, redirect_pc, imem_rdata, id_ready,
    input  imem_en, imem_addr, id_valid, id_instr, id_npc
  );

  // Fetch unit side.
  modport slave (
    input  redirect_valid, redirect_pc, imem_rdata, id_ready,
    output imem_en, imem_addr, id_valid, id_instr, id_npc
  );
endinterface

// File: rtl/inst_fetch_pf.sv
// Instruction prefetch unit: issues sequential reads into a 1-cycle memory and
// queues {instr, npc} in a small FIFO ahead of decode. Redirect flushes everything.
module inst_fetch_pf #(
  parameter int ADDR_W   = 10,
  parameter int INSTR_W  = 32,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  inst_fetch_pf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_cap_q, npc_cap_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic              inflight_q, inflight_d;
  logic              issue, push, pop;

  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [ADDR_W-1:0]  mem_npc   [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Issue/push/pop qualifiers; the outstanding read is reserved a slot so the FIFO cannot overflow.
  always_comb begin
    issue = !bus.redirect_valid &&
            (({1'b0, cnt_q} + {{CW{1'b0}}, inflight_q}) < (CW + 1)'(DEPTH));
    push  = inflight_q && !bus.redirect_valid;
    pop   = (cnt_q != '0) && bus.id_ready && !bus.redirect_valid;
  end

  // Next-state: redirect overrides every other update in the same cycle.
  always_comb begin
    pc_d       = pc_q;
    npc_cap_d  = npc_cap_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    inflight_d = inflight_q;
    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc;
      cnt_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      inflight_d = 1'b0;
    end else begin
      if (issue) begin
        pc_d      = pc_q + STEP;
        npc_cap_d = pc_q + STEP;
      end
      inflight_d = issue;
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RST_PC;
      npc_cap_q  <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      npc_cap_q  <= npc_cap_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
    end
  end

  // FIFO storage; contents are only observed through id_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wptr_q] <= bus.imem_rdata;
      mem_npc[wptr_q]   <= npc_cap_q;
    end
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = (cnt_q != '0);
  assign bus.id_instr  = mem_instr[rptr_q];
  assign bus.id_npc    = mem_npc[rptr_q];
endmodule

// File: tb/tb_inst_fetch_pf.sv
// Randomized self-checking bench for inst_fetch_pf against a queue-based fetch model.
module tb_inst_fetch_pf;
  localparam int ADDR_W = 10, INSTR_W = 32, DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_pf_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  inst_fetch_pf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
                  .PC_STEP(1), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Memory returns its address as data, one cycle after the request.
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= {{(INSTR_W-ADDR_W){1'b0}}, bus.imem_addr};

  int n_chk = 0, n_fail = 0, n_issue = 0;

  // Reference: fetch pc, FIFO of fetched addresses, single outstanding read.
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_q[$];
  logic              m_inf;
  logic [ADDR_W-1:0] m_inf_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_q.delete(); m_inf = 1'b0; m_inf_addr = '0;
  endtask

  // Called at a falling edge: drive, check combinational outputs, advance model, wait next falling edge.
  task automatic cycle(input logic rv, input logic [ADDR_W-1:0] rpc, input logic rdy);
    logic exp_en;
    logic [ADDR_W-1:0] nxt;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.id_ready       = rdy;
    #1;
    exp_en = !rv && ((m_q.size() + int'(m_inf)) < DEPTH);
    chk("imem_en",   bus.imem_en,   exp_en);
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("id_valid",  bus.id_valid,  m_q.size() != 0);
    if (m_q.size() != 0) begin
      nxt = m_q[0] + 1'b1;
      chk("id_instr", bus.id_instr, {{(INSTR_W-ADDR_W){1'b0}}, m_q[0]});
      chk("id_npc",   bus.id_npc,   nxt);
    end
    chk("cnt_le_depth", dut.cnt_q <= DEPTH, 1'b1);
    if (bus.imem_en) n_issue++;
    if (rv) begin
      m_pc = rpc; m_q.delete(); m_inf = 1'b0;
    end else begin
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_addr);
      if (exp_en) begin
        m_inf = 1'b1; m_inf_addr = m_pc; m_pc = m_pc + 1'b1;
      end else m_inf = 1'b0;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse from a falling edge; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_id_valid", bus.id_valid, 1'b0);
    chk("rst_addr",     bus.imem_addr, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_id_valid", bus.id_valid, 1'b0);
    chk("reset_addr",     bus.imem_addr, '0);
    rst_n = 1'b1;

    // Straight-line fetch with decode always ready.
    repeat (10) cycle(1'b0, '0, 1'b1);

    // Backpressure from a fresh reset: exactly DEPTH reads, then drain.
    async_reset();
    n_issue = 0;
    repeat (10) cycle(1'b0, '0, 1'b0);
    chk("stall_issues", n_issue, DEPTH);
    repeat (8) cycle(1'b0, '0, 1'b1);

    // Redirect with 3 buffered entries and a read in flight.
    async_reset();
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("pre_redir_cnt", dut.cnt_q, 3);
    cycle(1'b1, 10'h200, 1'b1);
    chk("post_redir_valid", bus.id_valid, 1'b0);
    repeat (6) cycle(1'b0, '0, 1'b1);

    // Back-to-back redirects, last one wins; then address wrap at 0x3FF.
    cycle(1'b1, 10'h123, 1'b1);
    cycle(1'b1, 10'h3FF, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1);

    // Full buffer, then asynchronous reset mid-stream and restart.
    repeat (6) cycle(1'b0, '0, 1'b0);
    async_reset();
    repeat (8) cycle(1'b0, '0, 1'b1);

    // Random stress.
    for (int i = 0; i < 3000; i++) begin
      logic rv, rdy;
      logic [ADDR_W-1:0] rpc;
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = ADDR_W'($urandom);
      if ($urandom_range(0, 7) == 0) rpc = 10'h3FE;
      cycle(rv, rpc, rdy);
      if ($urandom_range(0, 999) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
